// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if
//   Bundles every signal of the burst reader except clk/rst:
//     control : start, base_addr, len (in) / busy, done (out)
//     ROM bus : rom_r_en, rom_addr (out) / rom_data (in)
//     stream  : m_valid, m_data, m_last (out) / m_ready (in)
//   master : the reader's view (drives busy/done, ROM request, stream word)
//   slave  : the environment's view (drives commands, ROM data, m_ready)
//
//   Stream handshake: a word transfers on a rising clk edge where
//   m_valid & m_ready are both 1. Once m_valid is raised, m_valid, m_data
//   and m_last hold until that transfer; m_valid never depends on m_ready.
interface rom_stream_reader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 5
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic              rom_r_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      input  start, base_addr, len, rom_data, m_ready,
      output busy, done, rom_r_en, rom_addr, m_valid, m_data, m_last
   );

   modport slave (
      output start, base_addr, len, rom_data, m_ready,
      input  busy, done, rom_r_en, rom_addr, m_valid, m_data, m_last
   );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader
//   Burst read sequencer in front of a synchronous ROM with one cycle of
//   read latency. A start in IDLE captures base_addr/len; reads are issued
//   from base_addr upward (wrapping modulo 2^ADDR_W) and the returned words
//   are buffered in a small FIFO that feeds a valid/ready stream.
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous active-high reset
//     bus       rom_stream_reader_if.master (control, ROM bus, stream)
//     dbg_state current FSM state (0 IDLE, 1 READ, 2 DRAIN, 3 DONE)
module rom_stream_reader #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 5,
   parameter int FIFO_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   rom_stream_reader_if.master   bus,
   output logic [1:0]            dbg_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [LEN_W-1:0]  len_r;
   logic [LEN_W-1:0]  issued;
   logic              pend;       // ROM word arrives this cycle
   logic              pend_last;  // ...and it is the final word of the burst

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic              fifo_last [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;

   logic              issue, last_issue, push, pop, fifo_nonempty;
   logic [CNT_W:0]    credit_used;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check counts words already buffered plus the one in flight from
   // the ROM, so a read is only issued when a FIFO slot is guaranteed. Only
   // registered values feed it, keeping m_ready out of the rom_r_en path.
   assign credit_used   = {1'b0, count} + {{CNT_W{1'b0}}, pend};
   assign issue         = (state == S_READ) && (issued < len_r) && (credit_used < DEPTH_C);
   assign last_issue    = issue && (issued == len_r - LEN_W'(1));
   assign push          = pend;
   assign fifo_nonempty = (count != '0);
   assign pop           = fifo_nonempty && bus.m_ready;

   // FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = (bus.len == '0) ? S_DONE : S_READ;
         end
         S_READ: begin
            if (last_issue) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && fifo_last[rd_ptr]) state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      bus.busy     = (state == S_READ) || (state == S_DRAIN);
      bus.done     = (state == S_DONE);
      bus.rom_r_en = issue;
      bus.rom_addr = ptr;
      bus.m_valid  = fifo_nonempty;
      // Zeroed when empty so stale entries never show on the stream.
      bus.m_data   = fifo_nonempty ? fifo_data[rd_ptr] : '0;
      bus.m_last   = fifo_nonempty ? fifo_last[rd_ptr] : 1'b0;
      dbg_state    = state;
   end

   // Address pointer, burst counters and the read-latency tracker
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         len_r     <= '0;
         issued    <= '0;
         pend      <= 1'b0;
         pend_last <= 1'b0;
      end else begin
         pend      <= issue;
         pend_last <= last_issue;
         if (state == S_IDLE && bus.start) begin
            ptr    <= bus.base_addr;
            len_r  <= bus.len;
            issued <= '0;
         end else if (issue) begin
            ptr    <= ptr + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
            issued <= issued + LEN_W'(1);
         end
      end
   end

   // FIFO control
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // FIFO storage; the ROM word is captured in the single cycle it is valid
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= bus.rom_data;
         fifo_last[wr_ptr] <= pend_last;
      end
   end

endmodule
